// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the multiply/divide unit: operation encodings, latencies,
// FSM state type, debug view and the behavioural arithmetic helper.
package mult_div_unit_pkg;

  localparam logic [2:0] MD_OP_MULT  = 3'd0;
  localparam logic [2:0] MD_OP_MULTU = 3'd1;
  localparam logic [2:0] MD_OP_DIV   = 3'd2;
  localparam logic [2:0] MD_OP_DIVU  = 3'd3;

  localparam logic [3:0] MD_LAT_MULT = 4'd5;
  localparam logic [3:0] MD_LAT_DIV  = 4'd10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  typedef struct packed {
    md_state_t  state;
    logic [3:0] cnt;
  } md_dbg_t;

  function automatic logic md_op_valid(input logic [2:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  // Returns {hi, lo}. A zero divisor returns 'hold' so HI/LO keep their values.
  function automatic logic [63:0] md_compute(input logic [2:0]  op,
                                             input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [63:0] hold);
    logic [63:0] prod;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;
    logic        is_signed;
    prod      = '0;
    is_signed = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    ua        = (is_signed && a[31]) ? (~a + 32'd1) : a;
    ub        = (is_signed && b[31]) ? (~b + 32'd1) : b;
    uq        = '0;
    ur        = '0;
    q         = '0;
    r         = '0;
    if ((op == MD_OP_MULT) || (op == MD_OP_MULTU)) begin
      // Sign-extending to 64 bits makes the low 64 bits of the product correct
      // for the signed case without a signed multiplier.
      if (is_signed)
        prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      else
        prod = {32'd0, a} * {32'd0, b};
      return prod;
    end
    if (b == 32'd0)
      return hold;
    uq = ua / ub;
    ur = ua % ub;
    q  = (is_signed && (a[31] ^ b[31])) ? (~uq + 32'd1) : uq;
    r  = (is_signed && a[31]) ? (~ur + 32'd1) : ur;
    return {r, q};
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS HI/LO unit: result is computed at issue, held in temp
// registers, and committed to HI/LO when the latency counter expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output md_dbg_t     dbg
);

  // Handshake: start/mthi/mtlo are accepted only on an edge where busy=0 and
  // req=0; start wins over a simultaneous move. busy stays high from the issuing
  // edge until the commit edge, and HI/LO change only on that commit edge.

  md_state_t   state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] temp_hi, temp_hi_n;
  logic [31:0] temp_lo, temp_lo_n;
  logic [31:0] hi_q, hi_n;
  logic [31:0] lo_q, lo_n;
  logic [63:0] result;

  assign result = md_compute(op, A, B, {hi_q, lo_q});

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= MD_IDLE;
      cnt     <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      temp_hi <= temp_hi_n;
      temp_lo <= temp_lo_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    temp_hi_n = temp_hi;
    temp_lo_n = temp_lo;
    hi_n      = hi_q;
    lo_n      = lo_q;
    if (state == MD_IDLE) begin
      if (!req) begin
        if (start) begin
          // An unrecognised op is dropped together with any concurrent move.
          if (md_op_valid(op)) begin
            temp_hi_n = result[63:32];
            temp_lo_n = result[31:0];
            cnt_n     = ((op == MD_OP_MULT) || (op == MD_OP_MULTU)) ?
                        MD_LAT_MULT : MD_LAT_DIV;
            state_n   = MD_BUSY;
          end
        end else begin
          if (mthi) hi_n = wdata;
          if (mtlo) lo_n = wdata;
        end
      end
    end else begin
      if (cnt == 4'd1) begin
        hi_n    = temp_hi;
        lo_n    = temp_lo;
        cnt_n   = '0;
        state_n = MD_IDLE;
      end else begin
        cnt_n = cnt - 4'd1;
      end
    end
  end

  assign busy      = (state == MD_BUSY);
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg.state = state;
  assign dbg.cnt   = cnt;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: driver issues operations and pushes the
// expected {latency, HI, LO}; a monitor pops and compares on every busy fall.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  md_dbg_t     dbg;

  logic [67:0] exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  bit          abort_pending = 0;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .req   (req),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO),
    .dbg   (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin : monitor
    logic        prev_busy;
    int          busy_len;
    logic [67:0] e;
    prev_busy = 1'b0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (busy) begin
        busy_len = prev_busy ? busy_len + 1 : 1;
      end else if (prev_busy) begin
        if (abort_pending) begin
          abort_pending = 0;
        end else if (exp_q.size() == 0) begin
          check("unexpected_commit", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("busy_len", busy_len, {28'd0, e[67:64]});
          check("commit_hi", HI, e[63:32]);
          check("commit_lo", LO, e[31:0]);
        end
      end
      prev_busy = busy;
    end
  end

  // driver tasks
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] lat, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    exp_q.push_back({lat, eh, el});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] lat, input logic [31:0] eh, input logic [31:0] el);
    issue(o, a, b, lat, eh, el);
    wait_idle();
  endtask

  initial begin : driver
    reset = 1'b0;
    start = 1'b0;
    op    = '0;
    A     = '0;
    B     = '0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    wdata = '0;
    req   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_state", {31'd0, dbg.state}, {31'd0, MD_IDLE});
    reset = 1'b1;

    run(MD_OP_MULT,  32'hFFFFFFFF, 32'd2, 4'd5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run(MD_OP_MULTU, 32'hFFFFFFFF, 32'd2, 4'd5, 32'h00000001, 32'hFFFFFFFE);
    run(MD_OP_DIV,   32'hFFFFFFF9, 32'd2, 4'd10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run(MD_OP_DIVU,  32'hFFFFFFF9, 32'd2, 4'd10, 32'h00000001, 32'h7FFFFFFC);
    run(MD_OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 4'd5, 32'hFFFFFFFF, 32'h80000001);
    run(MD_OP_DIV,   32'd100, 32'hFFFFFFF9, 4'd10, 32'h00000002, 32'hFFFFFFF2);

    // moves, then divide by zero keeps them
    @(negedge clk); mthi = 1'b1; wdata = 32'h1234;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
    @(negedge clk); mtlo = 1'b0;
    check("mthi", HI, 32'h1234);
    check("mtlo", LO, 32'h5678);
    run(MD_OP_DIV, 32'd77, 32'd0, 4'd10, 32'h1234, 32'h5678);

    // req suppresses issue and moves
    @(negedge clk); start = 1'b1; req = 1'b1; op = MD_OP_MULT; A = 32'd3; B = 32'd5;
    @(negedge clk); start = 1'b0; mthi = 1'b1; wdata = 32'hFFFF;
    check("req_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); mthi = 1'b0; req = 1'b0;
    check("req_hi", HI, 32'h1234);
    check("req_lo", LO, 32'h5678);

    // start and moves during BUSY are ignored
    issue(MD_OP_MULT, 32'd3, 32'd5, 4'd5, 32'd0, 32'd15);
    start = 1'b1; op = MD_OP_DIV; A = 32'd9; B = 32'd4; mthi = 1'b1; mtlo = 1'b1;
    wdata = 32'hABCD;
    repeat (2) @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    wait_idle();
    check("no_reissue", {31'd0, busy}, 32'd0);

    // start beats a simultaneous move
    @(negedge clk);
    start = 1'b1; op = MD_OP_MULTU; A = 32'h00010000; B = 32'h00010000;
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD;
    exp_q.push_back({4'd5, 32'd1, 32'd0});
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    check("prio_hi", HI, 32'd0);
    check("prio_lo", LO, 32'd15);
    wait_idle();

    // unrecognised op
    @(negedge clk); start = 1'b1; op = 3'd5;
    @(negedge clk); start = 1'b0;
    check("badop_busy", {31'd0, busy}, 32'd0);
    check("badop_hi", HI, 32'd1);

    // reset in the middle of a multiply
    @(negedge clk); start = 1'b1; op = MD_OP_MULT; A = 32'd7; B = 32'd9;
    abort_pending = 1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("abort_late_busy", {31'd0, busy}, 32'd0);
    check("abort_late_lo", LO, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
